// File: rtl/mbtrain_eye_width_sweep.sv
// Eye-width sweep engine: steps the PI code 0..MAX_STEP, runs one point test per step and
// reports per-lane pass when the widest run of consecutive passing steps reaches MIN_WIDTH.
//
// state    | meaning
// IDLE     | waiting for i_en
// SETTLE   | PI code held while the receiver settles
// PT_START | one-cycle point-test request
// PT_WAIT  | waiting for i_pt_done or timeout
// EVAL     | update per-lane run/best, advance step
// DONE     | verdict valid, ack held until i_en falls
module mbtrain_eye_width_sweep #(
  parameter int NUM_LANES   = 16,
  parameter int PI_W        = 4,
  parameter int MAX_STEP    = 15,
  parameter int SETTLE_CYC  = 4,
  parameter int MIN_WIDTH   = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  input  logic                 i_pt_done,
  input  logic [NUM_LANES-1:0] i_pt_lanes_result,
  output logic [PI_W-1:0]      o_pi_step,
  output logic                 o_pt_start,
  output logic [NUM_LANES-1:0] o_tx_lanes_result,
  output logic                 o_test_ack,
  output logic                 o_busy,
  output logic                 o_timeout
);

  localparam int CW   = $clog2(MAX_STEP + 2);
  localparam int TMAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0]   SETTLE_LD  = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0]   TIMEOUT_LD = TW'(TIMEOUT_CYC - 1);
  localparam logic [PI_W-1:0] LAST_STEP  = PI_W'(MAX_STEP);
  localparam logic [CW-1:0]   MIN_W      = CW'(MIN_WIDTH);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETTLE   = 3'd1,
    PT_START = 3'd2,
    PT_WAIT  = 3'd3,
    EVAL     = 3'd4,
    DONE     = 3'd5
  } state_e;

  state_e                           state_q;
  logic [TW-1:0]                    timer_q;
  logic [PI_W-1:0]                  pi_q;
  logic                             start_q;
  logic [NUM_LANES-1:0]             result_q;
  logic                             ack_q;
  logic                             busy_q;
  logic                             timeout_q;
  logic [NUM_LANES-1:0]             lanes_q;
  logic [NUM_LANES-1:0][CW-1:0]     run_q;
  logic [NUM_LANES-1:0][CW-1:0]     best_q;
  logic [NUM_LANES-1:0][CW-1:0]     run_d;
  logic [NUM_LANES-1:0][CW-1:0]     best_d;
  logic [NUM_LANES-1:0]             pass_d;

  // Per-lane window tracking from the latched point-test result; consumed only in EVAL.
  always_comb begin
    run_d  = run_q;
    best_d = best_q;
    pass_d = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lanes_q[i]) begin
        run_d[i] = run_q[i] + CW'(1);
        if (run_d[i] > best_q[i]) best_d[i] = run_d[i];
      end else begin
        run_d[i] = '0;
      end
      pass_d[i] = (best_d[i] >= MIN_W);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      pi_q      <= '0;
      start_q   <= 1'b0;
      result_q  <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      lanes_q   <= '0;
      run_q     <= '0;
      best_q    <= '0;
    end else begin
      start_q <= 1'b0;
      // Dropping i_en covers both abort from a busy state and release from DONE.
      if (!i_en && state_q != IDLE) begin
        state_q <= IDLE;
        pi_q    <= '0;
        ack_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (i_en) begin
              state_q   <= SETTLE;
              run_q     <= '0;
              best_q    <= '0;
              timeout_q <= 1'b0;
              result_q  <= '0;
              pi_q      <= '0;
              timer_q   <= SETTLE_LD;
              busy_q    <= 1'b1;
            end
          end
          SETTLE: begin
            if (timer_q == '0) begin
              state_q <= PT_START;
              start_q <= 1'b1;
            end else begin
              timer_q <= timer_q - TW'(1);
            end
          end
          PT_START: begin
            state_q <= PT_WAIT;
            timer_q <= TIMEOUT_LD;
          end
          PT_WAIT: begin
            if (i_pt_done) begin
              lanes_q <= i_pt_lanes_result;
              state_q <= EVAL;
            end else if (timer_q == '0) begin
              lanes_q   <= '0;
              timeout_q <= 1'b1;
              state_q   <= EVAL;
            end else begin
              timer_q <= timer_q - TW'(1);
            end
          end
          EVAL: begin
            run_q  <= run_d;
            best_q <= best_d;
            if (pi_q == LAST_STEP) begin
              state_q  <= DONE;
              result_q <= pass_d;
              ack_q    <= 1'b1;
              busy_q   <= 1'b0;
            end else begin
              pi_q    <= pi_q + PI_W'(1);
              timer_q <= SETTLE_LD;
              state_q <= SETTLE;
            end
          end
          DONE: begin
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign o_pi_step         = pi_q;
  assign o_pt_start        = start_q;
  assign o_tx_lanes_result = result_q;
  assign o_test_ack        = ack_q;
  assign o_busy            = busy_q;
  assign o_timeout         = timeout_q;

endmodule

// File: tb/tb_mbtrain_eye_width_sweep.sv
// Directed bench for mbtrain_eye_width_sweep: full sweeps with scripted point-test results,
// timeout, abort, settle timing and asynchronous reset.
module tb_mbtrain_eye_width_sweep;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        done;
  logic [15:0] lanes_in;
  logic [3:0]  pi;
  logic        pt_start;
  logic [15:0] result;
  logic        ack;
  logic        busy;
  logic        tmo;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t_last = 0;
  logic [15:0] pat [16];

  always #5 clk = ~clk;

  mbtrain_eye_width_sweep dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_en              (en),
    .i_pt_done         (done),
    .i_pt_lanes_result (lanes_in),
    .o_pi_step         (pi),
    .o_pt_start        (pt_start),
    .o_tx_lanes_result (result),
    .o_test_ack        (ack),
    .o_busy            (busy),
    .o_timeout         (tmo)
  );

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // Advance to the next o_pt_start; gap is cycles since t_last.
  task automatic wait_start(output int gap);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!pt_start && n < 2000);
    checks++;
    if (pt_start !== 1'b1) begin
      errors++;
      $display("FAIL wait_start got no o_pt_start within %0d cycles", n);
    end
    gap    = cyc - t_last;
    t_last = cyc;
  endtask

  task automatic pulse_done(input logic [15:0] l);
    tick();
    done     = 1'b1;
    lanes_in = l;
    tick();
    done     = 1'b0;
    lanes_in = '0;
  endtask

  // One full sweep using pat[]; to_step < 0 means no point test is withheld.
  task automatic run_sweep(input string name, input int to_step, input logic [15:0] exp_res);
    int   gap;
    int   exp_gap;
    int   n;
    logic exp_tmo;
    en     = 1'b1;
    t_last = cyc;
    for (int s = 0; s < 16; s++) begin
      wait_start(gap);
      exp_gap = (s == 0) ? 5 : ((s - 1 == to_step) ? 1030 : 7);
      exp_tmo = (to_step >= 0 && s > to_step);
      checks++;
      if (pi !== 4'(s)) begin
        errors++;
        $display("FAIL %s pi_step at start %0d got %0d exp %0d", name, s, pi, s);
      end
      checks++;
      if (gap != exp_gap) begin
        errors++;
        $display("FAIL %s step_latency step %0d got %0d exp %0d", name, s, gap, exp_gap);
      end
      checks++;
      if (tmo !== exp_tmo) begin
        errors++;
        $display("FAIL %s timeout_flag step %0d got %b exp %b", name, s, tmo, exp_tmo);
      end
      if (s != to_step) pulse_done(pat[s]);
    end
    n = 0;
    while (!ack && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if ({ack, busy, pi} !== {1'b1, 1'b0, 4'd15}) begin
      errors++;
      $display("FAIL %s done_state got ack=%b busy=%b pi=%0d exp ack=1 busy=0 pi=15", name, ack, busy, pi);
    end
    checks++;
    if (result !== exp_res) begin
      errors++;
      $display("FAIL %s lanes_result got %h exp %h", name, result, exp_res);
    end
    checks++;
    if (tmo !== (to_step >= 0)) begin
      errors++;
      $display("FAIL %s final_timeout got %b exp %b", name, tmo, (to_step >= 0));
    end
    en = 1'b0;
    tick();
    checks++;
    if ({ack, pi, busy} !== 6'd0 || result !== exp_res) begin
      errors++;
      $display("FAIL %s release got ack=%b pi=%0d busy=%b res=%h exp ack=0 pi=0 busy=0 res=%h",
               name, ack, pi, busy, result, exp_res);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    en       = 1'b0;
    done     = 1'b0;
    lanes_in = '0;
    repeat (3) tick();
    checks++;
    if ({pi, pt_start, result, ack, busy, tmo} !== 25'd0) begin
      errors++;
      $display("FAIL reset_outputs got pi=%0d st=%b res=%h ack=%b busy=%b tmo=%b exp all 0",
               pi, pt_start, result, ack, busy, tmo);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_all_pass();
    for (int s = 0; s < 16; s++) pat[s] = 16'hFFFF;
    run_sweep("all_pass", -1, 16'hFFFF);
  endtask

  task automatic test_width_threshold();
    for (int s = 0; s < 16; s++) pat[s] = 16'h0000;
    pat[5] = 16'h0003;
    pat[6] = 16'h0003;
    pat[7] = 16'h0001;
    run_sweep("width", -1, 16'h0001);
  endtask

  // lane2: 1-2 and 9-12; lane3: even steps; lane0: 13-15; lane1: 0-1.
  task automatic test_split_windows();
    for (int s = 0; s < 16; s++) begin
      pat[s] = 16'h0000;
      if (s == 1 || s == 2 || (s >= 9 && s <= 12)) pat[s][2] = 1'b1;
      if (s % 2 == 0) pat[s][3] = 1'b1;
      if (s >= 13) pat[s][0] = 1'b1;
      if (s <= 1) pat[s][1] = 1'b1;
    end
    run_sweep("split", -1, 16'h0005);
  endtask

  task automatic test_timeout();
    for (int s = 0; s < 16; s++) pat[s] = 16'hFFFF;
    run_sweep("timeout", 3, 16'hFFFF);
  endtask

  task automatic test_abort();
    int gap;
    int starts;
    en     = 1'b1;
    t_last = cyc;
    for (int s = 0; s < 8; s++) begin
      wait_start(gap);
      if (s < 7) pulse_done(16'hFFFF);
    end
    tick();
    checks++;
    if (pi !== 4'd7 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre got pi=%0d busy=%b exp pi=7 busy=1", pi, busy);
    end
    en = 1'b0;
    tick();
    checks++;
    if ({pi, pt_start, busy, ack} !== 7'd0 || result !== 16'h0000) begin
      errors++;
      $display("FAIL abort_idle got pi=%0d st=%b busy=%b ack=%b res=%h exp all 0",
               pi, pt_start, busy, ack, result);
    end
    done     = 1'b1;
    lanes_in = 16'hFFFF;
    tick();
    done     = 1'b0;
    lanes_in = '0;
    starts   = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (pt_start) starts++;
    end
    checks++;
    if ({pi, busy, ack} !== 6'd0 || starts != 0) begin
      errors++;
      $display("FAIL abort_late_done got pi=%0d busy=%b ack=%b starts=%0d exp 0 0 0 0",
               pi, busy, ack, starts);
    end
    en     = 1'b1;
    t_last = cyc;
    wait_start(gap);
    checks++;
    if (pi !== 4'd0 || gap != 5) begin
      errors++;
      $display("FAIL abort_restart got pi=%0d gap=%0d exp pi=0 gap=5", pi, gap);
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_timing();
    int gap;
    int n;
    en     = 1'b1;
    t_last = cyc;
    wait_start(gap);
    checks++;
    if (gap != 5) begin
      errors++;
      $display("FAIL timing_first_start got %0d exp 5", gap);
    end
    done     = 1'b1;
    lanes_in = 16'hFFFF;
    tick();
    done     = 1'b0;
    lanes_in = '0;
    repeat (2) tick();
    checks++;
    if (pi !== 4'd0 || busy !== 1'b1 || pt_start !== 1'b0) begin
      errors++;
      $display("FAIL timing_done_in_start got pi=%0d busy=%b st=%b exp pi=0 busy=1 st=0", pi, busy, pt_start);
    end
    pulse_done(16'h0000);
    n = 0;
    while (pi !== 4'd1 && n < 10) begin
      tick();
      n++;
    end
    t_last = cyc;
    wait_start(gap);
    checks++;
    if (gap != 4 || pi !== 4'd1) begin
      errors++;
      $display("FAIL timing_settle got gap=%0d pi=%0d exp gap=4 pi=1", gap, pi);
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    int gap;
    en     = 1'b1;
    t_last = cyc;
    for (int s = 0; s < 3; s++) begin
      wait_start(gap);
      if (s < 2) pulse_done(16'hFFFF);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pi, pt_start, busy, ack} !== 7'd0) begin
      errors++;
      $display("FAIL async_reset got pi=%0d st=%b busy=%b ack=%b exp all 0", pi, pt_start, busy, ack);
    end
    en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_all_pass();
    test_width_threshold();
    test_split_windows();
    test_timeout();
    test_abort();
    test_timing();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
